// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the hazard controller and its mult/div timer.
// Optional mult/div tracking is enabled by defining HAZARD_MD_CTRL_EN.
package hazard_ctrl_pkg;

  localparam int REG_W    = 5;
  localparam int MD_CNT_W = 8;

  localparam logic [REG_W-1:0] ZERO_REG = '0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

  // Writes to r0 are discarded, so a load targeting r0 never creates a dependency.
  function automatic logic reg_dep(input logic [REG_W-1:0] dst, input logic [REG_W-1:0] src);
    return (dst != ZERO_REG) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_md_timer.sv
// Mult/div occupancy tracker: IDLE/BUSY FSM with a down-counter that times the unit latency.
// Only instantiated when HAZARD_MD_CTRL_EN is defined.
module hazard_md_timer
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_CYCLES = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic md_busy,
  output logic md_done
);

  md_state_e             state_q, state_d;
  logic [MD_CNT_W-1:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter holds the number of BUSY cycles still to come after the current one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          cnt_d   = MD_CNT_W'(MD_CYCLES - 1);
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - MD_CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    md_busy = (state_q == BUSY);
    md_done = (state_q == BUSY) && (cnt_q == '0);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and mult/div stalls, branch flush, stall-cycle counter.
// Mult/div tracking and the stall counter exist only when HAZARD_MD_CTRL_EN is defined.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_uses_hilo,
  input  logic             id_md_start,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_bubble,
  output logic             idex_bubble,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt
);

  logic lu_hazard;
  logic md_hazard;
  logic stall;

`ifdef HAZARD_MD_CTRL_EN
  logic             md_start;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // A start that is itself stalled or squashed must not launch the unit.
  assign md_start  = id_md_start & ~stall & ~ex_branch_taken;
  assign md_hazard = md_busy & id_uses_hilo;

  hazard_md_timer #(
    .MD_CYCLES (MD_CYCLES)
  ) u_md_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (md_start),
    .md_busy (md_busy),
    .md_done (md_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  logic unused_md_inputs;

  assign unused_md_inputs = ^{clk, rst_n, id_uses_hilo, id_md_start, (MD_CYCLES > 0)};
  assign md_hazard        = 1'b0;
  assign md_busy          = 1'b0;
  assign md_done          = 1'b0;
  assign stall_cnt        = '0;
`endif

  always_comb begin
    lu_hazard = ex_memread &
                (reg_dep(ex_rt, id_rs) | (id_uses_rt & reg_dep(ex_rt, id_rt)));
    stall     = (lu_hazard | md_hazard) & ~ex_branch_taken;
  end

  // A taken branch squashes both younger instructions, so it overrides any stall.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_bubble = 1'b0;
    idex_bubble = 1'b0;
    if (ex_branch_taken) begin
      ifid_bubble = 1'b1;
      idex_bubble = 1'b1;
    end else if (stall) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

endmodule
